// File: rtl/core_pio_in_gen2_if.sv
// Avalon-MM slave bus bundle for core_pio_in_gen2: word address, select,
// active-low write strobe, 32-bit data paths and the interrupt line.
interface core_pio_in_gen2_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata,
    input  irq
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata,
    output irq
  );
endinterface

// File: rtl/core_pio_in_gen2.sv
// Parametrised Avalon-MM input PIO: two-flop synchroniser, per-bit edge capture
// (W1C), level/edge irq. Define CORE_PIO_DEBOUNCE_EN to add the tick debouncer.
module core_pio_in_gen2 #(
  parameter int WIDTH    = 10,
  parameter int DB_W     = 16,
  parameter bit IRQ_EDGE = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in_port,
  core_pio_in_gen2_if.slave bus
);

  localparam logic [2:0] ADDR_DATA = 3'd0;
  localparam logic [2:0] ADDR_MASK = 3'd2;
  localparam logic [2:0] ADDR_EDGE = 3'd3;
  localparam logic [2:0] ADDR_RISE = 3'd4;
  localparam logic [2:0] ADDR_FALL = 3'd5;
  localparam logic [2:0] ADDR_DBP  = 3'd6;

  logic             wr_s;
  logic [WIDTH-1:0] wdata_s;
  logic             unused_wdata_s;

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] data_s;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] w1c_s;
  logic [WIDTH-1:0] rise_s, fall_s, edge_s;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_s;

  assign wr_s           = bus.chipselect && !bus.write_n;
  assign wdata_s        = bus.writedata[WIDTH-1:0];
  assign unused_wdata_s = ^bus.writedata;

`ifdef CORE_PIO_DEBOUNCE_EN
  logic [DB_W-1:0]  db_period_q, db_period_d;
  logic [DB_W-1:0]  presc_q, presc_d;
  logic [WIDTH-1:0] samp_q, samp_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] agree_s;
  logic             tick_s;

  // Prescaler and two-sample debounce: data only moves when consecutive ticks agree
  always_comb begin
    tick_s      = (presc_q == {DB_W{1'b0}});
    agree_s     = ~(s2_q ^ samp_q);
    db_period_d = db_period_q;
    if (wr_s && (bus.address == ADDR_DBP)) begin
      db_period_d = bus.writedata[DB_W-1:0];
      presc_d     = bus.writedata[DB_W-1:0];
    end else if (tick_s) begin
      presc_d = db_period_q;
    end else begin
      presc_d = presc_q - DB_W'(1);
    end
    if (tick_s) begin
      data_d = (samp_q & agree_s) | (data_q & ~agree_s);
      samp_d = s2_q;
    end else begin
      data_d = data_q;
      samp_d = samp_q;
    end
  end

  // Debouncer state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      db_period_q <= {DB_W{1'b0}};
      presc_q     <= {DB_W{1'b0}};
      samp_q      <= {WIDTH{1'b0}};
      data_q      <= {WIDTH{1'b0}};
    end else begin
      db_period_q <= db_period_d;
      presc_q     <= presc_d;
      samp_q      <= samp_d;
      data_q      <= data_d;
    end
  end

  assign data_s = data_q;
`else
  assign data_s = s2_q;
`endif

  // Register-write decode; a W1C pulse only exists on the cycle of the write
  always_comb begin
    irq_mask_d = irq_mask_q;
    rise_en_d  = rise_en_q;
    fall_en_d  = fall_en_q;
    w1c_s      = {WIDTH{1'b0}};
    if (wr_s) begin
      case (bus.address)
        ADDR_MASK: irq_mask_d = wdata_s;
        ADDR_EDGE: w1c_s      = wdata_s;
        ADDR_RISE: rise_en_d  = wdata_s;
        ADDR_FALL: fall_en_d  = wdata_s;
        default:   w1c_s      = {WIDTH{1'b0}};
      endcase
    end else begin
      w1c_s = {WIDTH{1'b0}};
    end
  end

  // Synchroniser, edge detect and capture; a fresh edge beats a same-cycle W1C
  always_comb begin
    s1_d           = in_port;
    s2_d           = s1_q;
    prev_d         = data_s;
    rise_s         = data_s & ~prev_q & rise_en_q;
    fall_s         = ~data_s & prev_q & fall_en_q;
    edge_s         = rise_s | fall_s;
    edge_capture_d = edge_s | (edge_capture_q & ~w1c_s);
  end

  // Read mux, zero-extended and registered every cycle
  always_comb begin
    readdata_d = 32'd0;
    case (bus.address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = data_s;
      ADDR_MASK: readdata_d[WIDTH-1:0] = irq_mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_capture_q;
      ADDR_RISE: readdata_d[WIDTH-1:0] = rise_en_q;
      ADDR_FALL: readdata_d[WIDTH-1:0] = fall_en_q;
`ifdef CORE_PIO_DEBOUNCE_EN
      ADDR_DBP:  readdata_d[DB_W-1:0]  = db_period_q;
`endif
      default:   readdata_d = 32'd0;
    endcase
  end

  // Interrupt source selected at elaboration: captured edges or live levels
  always_comb begin
    if (IRQ_EDGE) begin
      irq_s = |(edge_capture_q & irq_mask_q);
    end else begin
      irq_s = |(data_s & irq_mask_q);
    end
  end

  // Core register bank
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_q           <= {WIDTH{1'b0}};
      s2_q           <= {WIDTH{1'b0}};
      prev_q         <= {WIDTH{1'b0}};
      irq_mask_q     <= {WIDTH{1'b0}};
      edge_capture_q <= {WIDTH{1'b0}};
      rise_en_q      <= {WIDTH{1'b0}};
      fall_en_q      <= {WIDTH{1'b0}};
      readdata_q     <= 32'd0;
    end else begin
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      prev_q         <= prev_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
      rise_en_q      <= rise_en_d;
      fall_en_q      <= fall_en_d;
      readdata_q     <= readdata_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign bus.irq      = irq_s;

endmodule

// File: tb/tb_core_pio_in_gen2.sv
// Directed bench for core_pio_in_gen2: a vector table on the 10-bit edge-mode
// instance plus hand sequences for level mode, 32-bit width, reset and debounce.
module tb_core_pio_in_gen2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic [9:0]  in_m;
  logic [9:0]  in_l;
  logic [31:0] in_w;

  core_pio_in_gen2_if bus_m ();
  core_pio_in_gen2_if bus_l ();
  core_pio_in_gen2_if bus_w ();

  core_pio_in_gen2 #(.WIDTH(10), .DB_W(16), .IRQ_EDGE(1'b1)) u_main (
    .clk(clk), .reset_n(reset_n), .in_port(in_m), .bus(bus_m));
  core_pio_in_gen2 #(.WIDTH(10), .DB_W(16), .IRQ_EDGE(1'b0)) u_lvl (
    .clk(clk), .reset_n(reset_n), .in_port(in_l), .bus(bus_l));
  core_pio_in_gen2 #(.WIDTH(32), .DB_W(16), .IRQ_EDGE(1'b1)) u_wide (
    .clk(clk), .reset_n(reset_n), .in_port(in_w), .bus(bus_w));

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [9:0]  pin;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        chk_irq;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic w, input logic [2:0] a, input logic [31:0] wd,
                     input logic [9:0] p, input logic crd, input logic [31:0] erd,
                     input logic cirq, input logic eirq);
    vec_t t;
    t.wr = w; t.addr = a; t.wdata = wd; t.pin = p;
    t.chk_rd = crd; t.exp_rd = erd; t.chk_irq = cirq; t.exp_irq = eirq;
    vecs.push_back(t);
  endtask

  initial begin
    reset_n = 1'b0;
    in_m = 10'h3FF; in_l = 10'h000; in_w = 32'h0;
    bus_m.chipselect = 1'b0; bus_m.write_n = 1'b1; bus_m.address = 3'd0; bus_m.writedata = 32'h0;
    bus_l.chipselect = 1'b0; bus_l.write_n = 1'b1; bus_l.address = 3'd0; bus_l.writedata = 32'h0;
    bus_w.chipselect = 1'b0; bus_w.write_n = 1'b1; bus_w.address = 3'd0; bus_w.writedata = 32'h0;

    repeat (3) cyc();
    chk("reset readdata", bus_m.readdata, 32'h0);
    chk("reset irq", {31'd0, bus_m.irq}, 32'h0);
    chk("reset irq lvl", {31'd0, bus_l.irq}, 32'h0);
    reset_n = 1'b1;

`ifdef CORE_PIO_DEBOUNCE_EN
    begin
      logic seen;
      logic hit;
      in_m = 10'h000;
      bus_m.chipselect = 1'b1;
      repeat (6) cyc();
      bus_m.write_n = 1'b0; bus_m.address = 3'd6; bus_m.writedata = 32'd3;
      cyc();
      bus_m.write_n = 1'b1;
      cyc();
      chk("db_period readback", bus_m.readdata, 32'd3);
      bus_m.address = 3'd0;
      cyc(); cyc();
      in_m = 10'h001;
      cyc(); cyc();
      in_m = 10'h000;
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
        cyc();
        seen = seen | bus_m.readdata[0];
      end
      chk("glitch rejected", {31'd0, seen}, 32'h0);
      in_m = 10'h001;
      hit = 1'b0;
      for (int k = 0; k < 11; k++) begin
        cyc();
        if (bus_m.readdata == 32'h1) hit = 1'b1;
      end
      chk("debounced level accepted", {31'd0, hit}, 32'h1);
    end
`else
    // after release: 3rd read shows inputs, no capture while enables are 0
    add(1'b0, 3'd0, 32'h0,        10'h3FF, 1'b1, 32'h0,   1'b1, 1'b0);
    add(1'b0, 3'd0, 32'h0,        10'h3FF, 1'b1, 32'h0,   1'b0, 1'b0);
    add(1'b0, 3'd0, 32'h0,        10'h3FF, 1'b1, 32'h3FF, 1'b0, 1'b0);
    add(1'b0, 3'd3, 32'h0,        10'h3FF, 1'b1, 32'h0,   1'b1, 1'b0);
    // rising capture on bit 0
    add(1'b1, 3'd4, 32'h1,        10'h000, 1'b0, 32'h0,   1'b0, 1'b0);
    add(1'b1, 3'd2, 32'h1,        10'h000, 1'b0, 32'h0,   1'b1, 1'b0);
    add(1'b0, 3'd4, 32'h0,        10'h000, 1'b1, 32'h1,   1'b1, 1'b0);
    add(1'b0, 3'd2, 32'h0,        10'h001, 1'b1, 32'h1,   1'b1, 1'b0);
    add(1'b0, 3'd3, 32'h0,        10'h001, 1'b1, 32'h0,   1'b1, 1'b0);
    add(1'b0, 3'd3, 32'h0,        10'h001, 1'b1, 32'h0,   1'b1, 1'b1);
    add(1'b0, 3'd3, 32'h0,        10'h001, 1'b1, 32'h1,   1'b1, 1'b1);
    add(1'b0, 3'd3, 32'h0,        10'h000, 1'b1, 32'h1,   1'b1, 1'b1);
    add(1'b0, 3'd3, 32'h0,        10'h000, 1'b1, 32'h1,   1'b1, 1'b1);
    add(1'b0, 3'd3, 32'h0,        10'h000, 1'b1, 32'h1,   1'b1, 1'b1);
    add(1'b1, 3'd2, 32'h0,        10'h000, 1'b0, 32'h0,   1'b1, 1'b0);
    add(1'b1, 3'd3, 32'h1,        10'h000, 1'b0, 32'h0,   1'b1, 1'b0);
    add(1'b0, 3'd3, 32'h0,        10'h000, 1'b1, 32'h0,   1'b1, 1'b0);
    // falls on bits 1 and 2, then W1C racing a new fall on bit 1
    add(1'b1, 3'd5, 32'h3FF,      10'h006, 1'b0, 32'h0,   1'b0, 1'b0);
    add(1'b1, 3'd2, 32'h6,        10'h006, 1'b0, 32'h0,   1'b1, 1'b0);
    add(1'b0, 3'd0, 32'h0,        10'h006, 1'b1, 32'h6,   1'b0, 1'b0);
    add(1'b0, 3'd0, 32'h0,        10'h000, 1'b1, 32'h6,   1'b0, 1'b0);
    add(1'b0, 3'd0, 32'h0,        10'h000, 1'b1, 32'h6,   1'b0, 1'b0);
    add(1'b0, 3'd3, 32'h0,        10'h000, 1'b1, 32'h0,   1'b1, 1'b1);
    add(1'b0, 3'd3, 32'h0,        10'h002, 1'b1, 32'h6,   1'b1, 1'b1);
    add(1'b0, 3'd3, 32'h0,        10'h002, 1'b1, 32'h6,   1'b0, 1'b0);
    add(1'b0, 3'd3, 32'h0,        10'h002, 1'b1, 32'h6,   1'b0, 1'b0);
    add(1'b0, 3'd3, 32'h0,        10'h000, 1'b1, 32'h6,   1'b0, 1'b0);
    add(1'b0, 3'd3, 32'h0,        10'h000, 1'b1, 32'h6,   1'b0, 1'b0);
    add(1'b1, 3'd3, 32'h2,        10'h000, 1'b0, 32'h0,   1'b1, 1'b1);
    add(1'b0, 3'd3, 32'h0,        10'h000, 1'b1, 32'h6,   1'b1, 1'b1);
    add(1'b1, 3'd3, 32'h6,        10'h000, 1'b0, 32'h0,   1'b1, 1'b0);
    add(1'b0, 3'd3, 32'h0,        10'h000, 1'b1, 32'h0,   1'b1, 1'b0);
    // unmapped address 7 and address 6 without the debouncer
    add(1'b1, 3'd7, 32'hFFFFFFFF, 10'h000, 1'b0, 32'h0,   1'b1, 1'b0);
    add(1'b0, 3'd7, 32'h0,        10'h000, 1'b1, 32'h0,   1'b0, 1'b0);
    add(1'b1, 3'd6, 32'h0000FFFF, 10'h000, 1'b0, 32'h0,   1'b0, 1'b0);
    add(1'b0, 3'd6, 32'h0,        10'h000, 1'b1, 32'h0,   1'b0, 1'b0);
    add(1'b0, 3'd2, 32'h0,        10'h000, 1'b1, 32'h6,   1'b0, 1'b0);
    add(1'b0, 3'd5, 32'h0,        10'h000, 1'b1, 32'h3FF, 1'b0, 1'b0);
    add(1'b0, 3'd4, 32'h0,        10'h000, 1'b1, 32'h1,   1'b0, 1'b0);
    add(1'b0, 3'd1, 32'h0,        10'h000, 1'b1, 32'h0,   1'b0, 1'b0);

    foreach (vecs[i]) begin
      bus_m.chipselect = 1'b1;
      bus_m.write_n    = ~vecs[i].wr;
      bus_m.address    = vecs[i].addr;
      bus_m.writedata  = vecs[i].wdata;
      in_m             = vecs[i].pin;
      cyc();
      if (vecs[i].chk_rd)  chk($sformatf("vec%0d readdata", i), bus_m.readdata, vecs[i].exp_rd);
      if (vecs[i].chk_irq) chk($sformatf("vec%0d irq", i), {31'd0, bus_m.irq}, {31'd0, vecs[i].exp_irq});
    end
    bus_m.write_n = 1'b1;

    // level-mode irq follows data[4]
    bus_l.chipselect = 1'b1; bus_l.write_n = 1'b0; bus_l.address = 3'd2; bus_l.writedata = 32'h10;
    cyc();
    bus_l.write_n = 1'b1; bus_l.address = 3'd3; in_l = 10'h010;
    cyc();
    chk("lvl irq before sync", {31'd0, bus_l.irq}, 32'h0);
    cyc();
    chk("lvl irq high", {31'd0, bus_l.irq}, 32'h1);
    cyc();
    chk("lvl no capture", bus_l.readdata, 32'h0);
    in_l = 10'h000;
    cyc();
    chk("lvl irq still high", {31'd0, bus_l.irq}, 32'h1);
    cyc();
    chk("lvl irq dropped", {31'd0, bus_l.irq}, 32'h0);

    // 32-bit instance: all inputs rising together
    bus_w.chipselect = 1'b1; bus_w.write_n = 1'b0; bus_w.address = 3'd4; bus_w.writedata = 32'hFFFFFFFF;
    cyc();
    bus_w.write_n = 1'b1; bus_w.address = 3'd3; in_w = 32'hFFFFFFFF;
    cyc(); cyc(); cyc();
    chk("wide capture pending", bus_w.readdata, 32'h0);
    cyc();
    chk("wide capture all", bus_w.readdata, 32'hFFFFFFFF);
    chk("wide irq masked", {31'd0, bus_w.irq}, 32'h0);

    // reset mid-operation discards programmed enables
    bus_m.address = 3'd5;
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    chk("reset clears fall_en", bus_m.readdata, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
